// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, access sizes,
// byte-enable constants and small lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return addr_lo[0];
      WORD:    return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input size_t size, input logic [1:0] addr_lo);
    case (size)
      BYTE:    return BE_BYTE << addr_lo;
      HALF:    return BE_HALF << {addr_lo[1], 1'b0};
      default: return BE_WORD;
    endcase
  endfunction

  // Stores drive every lane so the memory only has to honour the byte enables.
  function automatic logic [31:0] replicate_store(input size_t size, input logic [31:0] data);
    case (size)
      BYTE:    return {4{data[7:0]}};
      HALF:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half lane from a 32-bit
// memory word and sign- or zero-extends it. Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  size_t       i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips an assignment infers a latch.
  always_comb begin
    w_byte = i_rdata[7:0];
    w_half = i_rdata[15:0];
    w_sign = 1'b0;
    o_data = i_rdata;

    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase

    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end

    case (i_size)
      BYTE: begin
        w_sign = ~i_unsigned & w_byte[7];
        o_data = {{24{w_sign}}, w_byte};
      end
      HALF: begin
        w_sign = ~i_unsigned & w_half[15];
        o_data = {{16{w_sign}}, w_half};
      end
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access, sub-word store lane
// replication, load alignment and write-back. Define LSU_TIMEOUT_EN to add the ack watchdog.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err,
  output logic              busy
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;
  logic              r_we;
  size_t             r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic [31:0]       r_wb_data;
  logic              r_err;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_start_mem;
  logic              w_load_ack;
  logic              w_timeout;
  logic [31:0]       w_align_data;

  assign w_misaligned = is_misaligned(size_t'(req_size), req_addr[1:0]);
  assign w_start_mem  = w_accept & ~w_misaligned;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (w_start_mem) begin
      r_tmo_cnt <= '0;
    end else if (r_state == MEM) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  // An ack arriving in the final allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == MEM) && !mem_ack &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the unit waits in MEM for as long as the ack takes.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_load_ack   = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (!w_misaligned) begin
            w_next_state = MEM;
          end
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (r_we) begin
            w_next_state = IDLE;
          end else begin
            w_load_ack   = 1'b1;
            w_next_state = WB;
          end
        end else if (w_timeout) begin
          w_next_state = IDLE;
        end
      end
      WB:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_size     <= BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= (w_accept & w_misaligned) | w_timeout;
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= size_t'(req_size);
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_rd       <= req_rd;
      end
      if (w_load_ack) begin
        r_wb_data <= w_align_data;
      end
    end
  end

  lsu_load_align u_load_align (
    .i_rdata    (mem_rdata),
    .i_addr_lo  (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_align_data)
  );

  // Memory and write-back ports read zero whenever they are not in use.
  assign mem_req   = (r_state == MEM);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? replicate_store(r_size, r_wdata) : '0;
  assign mem_be    = mem_req ? byte_enable(r_size, r_addr[1:0]) : '0;

  assign wb_valid  = (r_state == WB);
  assign wb_rd     = wb_valid ? r_rd : '0;
  assign wb_data   = wb_valid ? r_wb_data : '0;

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scenario tasks plus a scoreboard of
// expected memory requests, write-backs and error pulses.
module tb_load_store_unit;

  localparam int ADDR_W = 32;
  localparam int TMO    = 4;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              err;
  logic              busy;

  load_store_unit #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  mem_exp_t    exp_mem[$];
  wb_exp_t     exp_wb[$];
  int          exp_err_cnt;
  int          n_checks;
  int          n_errors;
  logic        prev_mem_req;
  logic [68:0] held_mem;
  bit          sampled;

  // ---------------- reference model ----------------
  function automatic logic misaligned_model(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return a[0];
    if (sz == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_model(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   return {w[7:0], w[7:0], w[7:0], w[7:0]};
      2'b01:   return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] d, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = d >> (8 * off);
    case (sz)
      2'b00:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return d;
    endcase
  endfunction

  // ---------------- scoreboard monitor, run once per cycle at the falling edge ----------------
  task automatic run_monitor();
    mem_exp_t m;
    wb_exp_t  w;
    if (mem_req) begin
      n_checks++;
      if (!prev_mem_req) begin
        if (exp_mem.size() == 0) begin
          n_errors++;
          $display("FAIL mem_req_unexpected: got addr=%h be=%b we=%b, required no access",
                   mem_addr, mem_be, mem_we);
        end else begin
          m = exp_mem.pop_front();
          if (mem_we !== m.we || mem_addr !== m.addr || mem_be !== m.be || mem_wdata !== m.wdata) begin
            n_errors++;
            $display("FAIL mem_fields: got we=%b addr=%h be=%b wdata=%h, required we=%b addr=%h be=%b wdata=%h",
                     mem_we, mem_addr, mem_be, mem_wdata, m.we, m.addr, m.be, m.wdata);
          end
        end
        held_mem = {mem_we, mem_addr, mem_be, mem_wdata};
      end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== held_mem) begin
        n_errors++;
        $display("FAIL mem_stable: got %h, required %h", {mem_we, mem_addr, mem_be, mem_wdata}, held_mem);
      end
    end
    prev_mem_req = mem_req;

    if (wb_valid) begin
      n_checks++;
      if (exp_wb.size() == 0) begin
        n_errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write-back", wb_rd, wb_data);
      end else begin
        w = exp_wb.pop_front();
        if (wb_rd !== w.rd || wb_data !== w.data) begin
          n_errors++;
          $display("FAIL wb_fields: got rd=%0d data=%h, required rd=%0d data=%h", wb_rd, wb_data, w.rd, w.data);
        end
      end
    end

    if (err) begin
      n_checks++;
      if (exp_err_cnt == 0) begin
        n_errors++;
        $display("FAIL err_unexpected: got err=1, required 0");
      end else begin
        exp_err_cnt--;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    run_monitor();
    sampled = 1'b1;
  endtask

  task automatic advance();
    if (!sampled) sample();
    sampled = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) advance();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_ready_timeout: got req_ready=%b, required 1 within 50 cycles", name, req_ready);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    mem_exp_t m;
    m.we    = we;
    m.addr  = addr & 32'hFFFF_FFFC;
    m.be    = be;
    m.wdata = wdata;
    exp_mem.push_back(m);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_exp_t w;
    w.rd   = rd;
    w.data = data;
    exp_wb.push_back(w);
  endtask

  // One complete access; the ack arrives ack_at cycles after the accept edge.
  task automatic do_access(input string name, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic [31:0] rdata, input int ack_at,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_load);
    logic mis;
    mis = misaligned_model(size, addr);
    wait_ready(name);
    drive_req(we, size, uns, addr, wdata, rd);
    if (mis) exp_err_cnt++;
    else push_mem(we, addr, exp_be, exp_wdata);
    advance();
    req_valid = 1'b0;
    if (mis) begin
      sample();
      n_checks++;
      if (err !== 1'b1 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_misaligned: got err=%b mem_req=%b req_ready=%b, required 1 0 1",
                 name, err, mem_req, req_ready);
      end
      advance();
      sample();
      n_checks++;
      if (err !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_err_pulse: got err=%b mem_req=%b req_ready=%b, required 0 0 1",
                 name, err, mem_req, req_ready);
      end
      advance();
    end else begin
      for (int i = 1; i < ack_at; i++) advance();
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      if (!we) push_wb(rd, exp_load);
      sample();
      n_checks++;
      if (mem_req !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_req_at_ack: got mem_req=%b, required 1", name, mem_req);
      end
      advance();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      sample();
      n_checks++;
      if (wb_valid !== ~we || mem_req !== 1'b0 || busy !== ~we) begin
        n_errors++;
        $display("FAIL %s_after_ack: got wb_valid=%b mem_req=%b busy=%b, required %b 0 %b",
                 name, wb_valid, mem_req, busy, ~we, ~we);
      end
      advance();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    sample();
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || mem_be !== '0 || wb_valid !== 1'b0 ||
        wb_rd !== '0 || wb_data !== '0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got ready=%b busy=%b req=%b we=%b addr=%h wdata=%h be=%b wbv=%b rd=%0d wbd=%h err=%b, required ready=1 others 0",
               req_ready, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_valid, wb_rd, wb_data, err);
    end
    advance();
    rst = 1'b1;
    advance();
  endtask

  task automatic test_spec_vectors();
    do_access("byte_load_signed", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 5'd9, 32'h80FF_1234, 3,
              4'b1000, 32'h0, 32'hFFFF_FF80);
    do_access("byte_load_unsigned", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 5'd10, 32'h80FF_1234, 3,
              4'b1000, 32'h0, 32'h0000_0080);
    do_access("half_store", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 5'd0, 32'h0, 2,
              4'b1100, 32'hABCD_ABCD, 32'h0);
    do_access("word_load_misaligned", 1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 5'd4, 32'h0, 1,
              4'b0000, 32'h0, 32'h0);
    do_access("half_load_misaligned", 1'b0, 2'b01, 1'b0, 32'h33, 32'h0, 5'd4, 32'h0, 1,
              4'b0000, 32'h0, 32'h0);
    do_access("reserved_size", 1'b1, 2'b11, 1'b0, 32'h40, 32'h1, 5'd4, 32'h0, 1,
              4'b0000, 32'h0, 32'h0);
  endtask

  task automatic test_load_patterns();
    logic [31:0] d;
    logic [31:0] a;
    d = 32'h8A7F_C312;
    for (int off = 0; off < 4; off++) begin
      for (int u = 0; u < 2; u++) begin
        a = 32'h0000_1000 + 32'(off);
        do_access("byte_load", 1'b0, 2'b00, u[0], a, 32'h0, 5'(off + 1), d, 1 + (off % 3),
                  be_model(2'b00, a[1:0]), 32'h0, load_model(d, a[1:0], 2'b00, u[0]));
      end
    end
    for (int off = 0; off < 4; off += 2) begin
      for (int u = 0; u < 2; u++) begin
        a = 32'h0000_2000 + 32'(off);
        do_access("half_load", 1'b0, 2'b01, u[0], a, 32'h0, 5'd20, d, 2,
                  be_model(2'b01, a[1:0]), 32'h0, load_model(d, a[1:0], 2'b01, u[0]));
      end
    end
    do_access("word_load", 1'b0, 2'b10, 1'b0, 32'h3004, 32'h0, 5'd31, d, 1,
              be_model(2'b10, 2'b00), 32'h0, d);
  endtask

  task automatic test_store_patterns();
    logic [31:0] a;
    logic [31:0] w;
    for (int off = 0; off < 4; off++) begin
      a = 32'h0000_4000 + 32'(off);
      w = 32'h1234_5600 | 32'($urandom_range(0, 255));
      do_access("byte_store", 1'b1, 2'b00, 1'b0, a, w, 5'd0, 32'h0, 1 + off,
                be_model(2'b00, a[1:0]), wdata_model(2'b00, w), 32'h0);
    end
    do_access("word_store", 1'b1, 2'b10, 1'b0, 32'h5008, 32'hDEAD_BEEF, 5'd0, 32'h0, 2,
              4'b1111, 32'hDEAD_BEEF, 32'h0);
  endtask

  task automatic test_ack_ignored_idle();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    advance();
    sample();
    n_checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ack_idle: got wb_valid=%b busy=%b mem_req=%b ready=%b, required 0 0 0 1",
               wb_valid, busy, mem_req, req_ready);
    end
    advance();
    mem_ack = 1'b0;
    advance();
  endtask

  task automatic test_back_to_back();
    wait_ready("b2b");
    drive_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3);
    push_mem(1'b0, 32'h100, 4'b1111, 32'h0);
    advance();
    drive_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_005A, 5'd0);
    push_mem(1'b1, 32'h101, 4'b0010, 32'h5A5A_5A5A);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    push_wb(5'd3, 32'h1122_3344);
    sample();
    n_checks++;
    if (req_ready !== 1'b0 || mem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_hold_mem: got ready=%b mem_req=%b, required 0 1", req_ready, mem_req);
    end
    advance();
    mem_ack = 1'b0;
    sample();
    n_checks++;
    if (req_ready !== 1'b0 || wb_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_hold_wb: got ready=%b wb_valid=%b, required 0 1", req_ready, wb_valid);
    end
    advance();
    sample();
    n_checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle: got ready=%b wb_valid=%b, required 1 0", req_ready, wb_valid);
    end
    advance();
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    sample();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_no_bubble: got mem_req=%b mem_we=%b, required 1 1", mem_req, mem_we);
    end
    advance();
    mem_ack = 1'b0;
    advance();
  endtask

  task automatic test_reset_in_mem();
    wait_ready("rst_mem");
    drive_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 5'd7);
    push_mem(1'b0, 32'h80, 4'b1111, 32'h0);
    advance();
    req_valid = 1'b0;
    advance();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async: got mem_req=%b ready=%b busy=%b wb_valid=%b err=%b, required 0 1 0 0 0",
               mem_req, req_ready, busy, wb_valid, err);
    end
    advance();
    advance();
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    advance();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    sample();
    n_checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_release: got ready=%b wb_valid=%b mem_req=%b, required 1 0 0",
               req_ready, wb_valid, mem_req);
    end
    advance();
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    wait_ready("timeout");
    drive_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd12);
    push_mem(1'b0, 32'h40, 4'b1111, 32'h0);
    exp_err_cnt++;
    advance();
    req_valid = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      sample();
      n_checks++;
      if (mem_req !== 1'b1) begin
        n_errors++;
        $display("FAIL timeout_req_cycle%0d: got mem_req=%b, required 1", i, mem_req);
      end
      advance();
    end
    sample();
    n_checks++;
    if (mem_req !== 1'b0 || err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_expire: got mem_req=%b err=%b ready=%b busy=%b wb_valid=%b, required 0 1 1 0 0",
               mem_req, err, req_ready, busy, wb_valid);
    end
    advance();
    sample();
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_err_pulse: got err=%b, required 0", err);
    end
    advance();
  endtask
`else
  task automatic test_long_wait();
    do_access("long_wait_store", 1'b1, 2'b10, 1'b0, 32'h6000, 32'h0BAD_F00D, 5'd0, 32'h0, 12,
              4'b1111, 32'h0BAD_F00D, 32'h0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_err_cnt  = 0;
    prev_mem_req = 1'b0;
    held_mem     = '0;
    sampled      = 1'b0;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_rd       = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;

    test_reset();
    test_spec_vectors();
    test_load_patterns();
    test_store_patterns();
    test_ack_ignored_idle();
    test_back_to_back();
    test_reset_in_mem();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    advance();

    n_checks++;
    if (exp_mem.size() != 0 || exp_wb.size() != 0 || exp_err_cnt != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got pending mem=%0d wb=%0d err=%0d, required 0 0 0",
               exp_mem.size(), exp_wb.size(), exp_err_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the byte-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the memory-acknowledge watchdog limit.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: execute stage offers an access.
REQ-006 SHALL have port req_ready, output, 1 bit: the unit accepts an access.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned, input, 1 bit: load zero-extends when 1.
REQ-010 SHALL have port req_addr, input, ADDR_W bits: the ALU result.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data (RD2).
REQ-012 SHALL have port req_rd, input, 5 bits: load destination register.
REQ-013 SHALL have mem_req out 1, mem_we out 1, mem_addr out ADDR_W (word-aligned), mem_wdata out 32, mem_be out 4, mem_ack in 1 and mem_rdata in 32 as the data-memory port.
REQ-014 SHALL have wb_valid out 1, wb_rd out 5 and wb_data out 32 as the register-file write-back port.
REQ-015 SHALL have err out 1 (one-cycle error pulse) and busy out 1.

Function
REQ-016 SHALL implement FSM states IDLE, MEM and WB; req_ready = (state==IDLE); busy = (state!=IDLE).
REQ-017 SHALL accept a request on a cycle with req_valid && req_ready, registering all req_* fields.
REQ-018 SHALL treat as misaligned: half with addr[0]=1, word with addr[1:0]!=0, and any size 11.
REQ-019 SHALL, on a misaligned accept, issue no memory access, pulse err on the next cycle and stay in IDLE.
REQ-020 SHALL, on an aligned accept, go to MEM and assert mem_req from the next cycle until the cycle mem_ack is sampled high, inclusive.
REQ-021 SHALL hold mem_addr = {addr[ADDR_W-1:2],2'b00}, mem_we, mem_wdata and mem_be stable while mem_req is high.
REQ-022 SHALL set mem_be to 0001<<addr[1:0] for byte, 0011<<{addr[1],1'b0} for half and 1111 for word.
REQ-023 SHALL replicate the store data: byte on all four lanes, half on both halves.
REQ-024 SHALL ignore mem_ack while mem_req is low.
REQ-025 SHALL, on a store ack, return to IDLE with no write-back.
REQ-026 SHALL, on a load ack, go to WB, registering the lane-selected and extended mem_rdata.
REQ-027 SHALL make WB last exactly one cycle, with wb_valid=1, wb_rd=req_rd and wb_data valid, then go to IDLE.
REQ-028 SHALL give a load latency of acceptance cycle N, ack cycle M>=N+1, and wb_valid at M+1.
REQ-029 SHALL sign-extend bit 7 (byte) or bit 15 (half) unless req_unsigned is set.
REQ-030 SHALL, when req_valid is held during MEM/WB, not accept it until IDLE, and then accept it with no bubble.

Reset
REQ-031 SHALL, while rst is low, immediately force state IDLE, with req_ready=1 and all other outputs 0.
REQ-032 SHALL, on reset during MEM, drop mem_req asynchronously and discard the pending access with no write-back.

Configuration
REQ-033 SHALL, with LSU_TIMEOUT_EN defined, count MEM cycles; if TIMEOUT_CYCLES elapse without an ack, it drops mem_req, pulses err, skips write-back and returns to IDLE; the counter clears on entering MEM.
REQ-034 SHALL, with LSU_TIMEOUT_EN undefined, have no counter and wait in MEM indefinitely.

Structure
REQ-035 SHALL place the lsu_state_t enum, the size_t encodings (BYTE/HALF/WORD) and the BE constants in a shared package, lsu_pkg.
REQ-036 SHALL implement one sub-module, lsu_load_align, as combinational lane selection and extension from mem_rdata, addr[1:0], size and unsigned.

Verification
REQ-037 SHALL check: a byte load at addr 0x13 with mem_rdata 0x80FF_1234 and ack 3 cycles later -> mem_be 1000 and wb_data 0xFFFF_FF80 one cycle after ack.
REQ-038 SHALL check: the same with req_unsigned=1 -> wb_data 0x0000_0080.
REQ-039 SHALL check: a half store of 0xABCD at 0x22 -> mem_addr 0x20, mem_be 1100, mem_wdata 0xABCD_ABCD, and no wb_valid.
REQ-040 SHALL check: a word load at 0x05 -> err pulses 1 cycle, mem_req never rises, and req_ready stays 1.
REQ-041 SHALL check: rst low 2 cycles into MEM -> mem_req 0 immediately, no wb_valid after release, and req_ready=1.
REQ-042 SHALL check, with LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no ack -> mem_req falls after 4 cycles, err pulses, state IDLE.
